// File: rtl/traffic_demand_arbiter.sv
// Debounces four vehicle-loop sensors into latched per-approach demand and offers
// one green phase at a time to the controller in round-robin order.
module traffic_demand_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor_in,
  input  logic       req_ready,
  input  logic       service_valid,
  input  logic [1:0] service_lane,
  output logic       req_valid,
  output logic [1:0] req_lane,
  output logic [3:0] demand,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StOffer, StWaitDone} state_e;

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync_q;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       demand_q, demand_d;
  logic [3:0]       rise, clr;

  state_e     state_q, state_d;
  logic [1:0] req_lane_q, req_lane_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] pick;
  logic       found;

  // Counter runs only while the synchronized level disagrees with the accepted one.
  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          deb_d[i] = sync_q[i];
          rise[i]  = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A new rising edge outranks a same-cycle service clear.
  always_comb begin
    clr      = service_valid ? (4'b0001 << service_lane) : 4'b0000;
    demand_d = (demand_q & ~clr) | rise;
  end

  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && demand_q[last_grant_q + 2'(k)]) begin
        pick  = last_grant_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_lane_d   = req_lane_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (demand_q != 4'b0000) begin
          req_lane_d = pick;
          state_d    = StOffer;
        end
      end
      StOffer: begin
        if (req_ready) begin
          last_grant_d = req_lane_q;
          state_d      = StWaitDone;
        end
      end
      StWaitDone: begin
        if (service_valid && (service_lane == last_grant_q)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync_q       <= '0;
      deb_q        <= '0;
      demand_q     <= '0;
      state_q      <= StIdle;
      req_lane_q   <= 2'd0;
      last_grant_q <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= sensor_in;
      sync_q       <= sync1_q;
      deb_q        <= deb_d;
      demand_q     <= demand_d;
      state_q      <= state_d;
      req_lane_q   <= req_lane_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Decoded from state so that reset drops the offer without waiting for a clock.
  assign req_valid = (state_q == StOffer);
  assign busy      = (state_q != StIdle);
  assign req_lane  = req_lane_q;
  assign demand    = demand_q;

endmodule

// File: tb/tb_traffic_demand_arbiter.sv
// Directed and randomized bench for traffic_demand_arbiter against a history-based
// behavioural model.
module tb_traffic_demand_arbiter;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sensor_in;
  logic       req_ready;
  logic       service_valid;
  logic [1:0] service_lane;
  logic       req_valid;
  logic [1:0] req_lane;
  logic [3:0] demand;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  traffic_demand_arbiter #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sensor_in(sensor_in),
    .req_ready(req_ready),
    .service_valid(service_valid),
    .service_lane(service_lane),
    .req_valid(req_valid),
    .req_lane(req_lane),
    .demand(demand),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: raw samples delayed two edges, a level is accepted once the
  // last D synchronized samples all disagree with the current level.
  bit [3:0] in_hist[$];
  bit [3:0] syn_hist[$];
  bit [3:0] m_deb, m_dem;
  int       m_state;  // 0 idle, 1 offering, 2 waiting for service
  bit [1:0] m_lane, m_last;

  function automatic bit [1:0] rr_pick(input bit [3:0] d, input bit [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int l = (int'(last) + k) % 4;
      if (d[l]) return 2'(l);
    end
    return last;
  endfunction

  task automatic model_reset();
    in_hist = {4'b0000, 4'b0000};
    syn_hist.delete();
    repeat (D) syn_hist.push_back(4'b0000);
    m_deb = '0; m_dem = '0; m_state = 0; m_lane = 2'd0; m_last = 2'd3;
  endtask

  task automatic model_step();
    bit [3:0] sy, rise, newdeb, clrm;
    bit       all;
    sy = in_hist.pop_front();
    in_hist.push_back(sensor_in);
    void'(syn_hist.pop_front());
    syn_hist.push_back(sy);
    rise = '0;
    newdeb = m_deb;
    for (int i = 0; i < 4; i++) begin
      all = 1'b1;
      for (int k = 0; k < D; k++) if (syn_hist[k][i] == m_deb[i]) all = 1'b0;
      if (all) begin
        newdeb[i] = sy[i];
        rise[i]   = sy[i];
      end
    end
    case (m_state)
      0: if (m_dem != 0) begin m_lane = rr_pick(m_dem, m_last); m_state = 1; end
      1: if (req_ready) begin m_last = m_lane; m_state = 2; end
      default: if (service_valid && service_lane == m_last) m_state = 0;
    endcase
    clrm  = service_valid ? (4'b0001 << service_lane) : 4'b0000;
    m_dem = (m_dem & ~clrm) | rise;
    m_deb = newdeb;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    chk("cmp_req_valid", req_valid, (m_state == 1));
    chk("cmp_req_lane", req_lane, m_lane);
    chk("cmp_demand", demand, m_dem);
    chk("cmp_busy", busy, (m_state != 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sensor_in = '0; req_ready = 1'b0; service_valid = 1'b0; service_lane = 2'd0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!req_valid && n < budget) begin
      step();
      n++;
    end
    if (!req_valid) chk(name, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit [1:0] exp_order [3];
    logic [3:0] acc;
    int hold [4];

    rst = 1'b0;
    sensor_in = '0; req_ready = 1'b0; service_valid = 1'b0; service_lane = 2'd0;
    #1;
    chk("reset_req_valid", req_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_demand", demand, 4'b0000);
    chk("reset_req_lane", req_lane, 2'd0);
    step();
    step();
    rst = 1'b1;

    // Short glitch on lane 1 must be rejected.
    sensor_in[1] = 1'b1;
    repeat (3) step();
    sensor_in[1] = 1'b0;
    acc = '0;
    repeat (12) begin
      step();
      acc = acc | demand | {3'b000, req_valid};
    end
    chk("glitch_rejected", acc, 4'b0000);

    // Held sensor on lane 2: demand after D+2 edges, request one edge later.
    sensor_in[2] = 1'b1;
    repeat (5) step();
    chk("lat_demand_before", demand, 4'b0000);
    step();
    chk("lat_demand_at", demand, 4'b0100);
    chk("lat_model_demand", m_dem, 4'b0100);
    chk("lat_no_req_yet", req_valid, 0);
    step();
    chk("lat_req_valid", req_valid, 1);
    chk("lat_req_lane", req_lane, 2'd2);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stable_req_valid", req_valid, 1);
      chk("stable_req_lane", req_lane, 2'd2);
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("accept_drops_valid", req_valid, 0);
    chk("accept_busy", busy, 1);
    service_valid = 1'b1; service_lane = 2'd2;
    step();
    service_valid = 1'b0;
    chk("service_idle", busy, 0);
    chk("service_clears", demand, 4'b0000);
    sensor_in = '0;
    repeat (8) step();

    // Round robin from last_grant=3 over demand 1011.
    do_reset();
    sensor_in = 4'b1011;
    repeat (6) step();
    chk("rr_demand", demand, 4'b1011);
    sensor_in = '0;
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      wait_valid(10, "rr_wait_timeout");
      chk("rr_grant", req_lane, exp_order[k]);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      service_valid = 1'b1; service_lane = exp_order[k];
      step();
      service_valid = 1'b0;
    end
    chk("rr_done_busy", busy, 0);
    chk("rr_done_demand", demand, 4'b0000);

    // Service clear coincident with the debounced rise: set wins.
    do_reset();
    sensor_in[2] = 1'b1;
    repeat (5) step();
    service_valid = 1'b1; service_lane = 2'd2;
    step();
    service_valid = 1'b0;
    chk("set_beats_clear", demand[2], 1);

    // Asynchronous reset in the middle of an offer.
    do_reset();
    sensor_in = 4'b0001;
    wait_valid(20, "offer_wait_timeout");
    chk("offer_before_reset", req_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", req_valid, 0);
    chk("async_rst_demand", demand, 4'b0000);
    chk("async_rst_busy", busy, 0);
    sensor_in = '0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_demand", demand, 4'b0000);

    // Randomized traffic with an ideal-ish controller and stray service pulses.
    do_reset();
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          sensor_in[i] = 1'($urandom % 2);
          hold[i] = $urandom_range(1, 10);
        end else begin
          hold[i]--;
        end
      end
      req_ready = ($urandom % 3 == 0);
      if (m_state == 2 && $urandom % 4 == 0) begin
        service_valid = 1'b1; service_lane = m_last;
      end else if ($urandom % 20 == 0) begin
        service_valid = 1'b1; service_lane = 2'($urandom % 4);
      end else begin
        service_valid = 1'b0;
      end
      if ($urandom % 500 == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      step();
    end
    service_valid = 1'b0;
    req_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
